// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the convolution block sequencer:
// state encoding, host command opcodes and status error codes.
package conv_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_GAP  = 3'd2,
      ST_SOP  = 3'd3,
      ST_RUN  = 3'd4,
      ST_DONE = 3'd5
   } seqState_t;

   localparam logic [1:0] OP_NOP   = 2'd0;
   localparam logic [1:0] OP_START = 2'd1;
   localparam logic [1:0] OP_ABORT = 2'd2;
   localparam logic [1:0] OP_RSVD  = 2'd3;

   localparam logic [1:0] ERR_NONE         = 2'd0;
   localparam logic [1:0] ERR_BAD_CMD      = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT      = 2'd2;
   localparam logic [1:0] ERR_SPURIOUS_EOP = 2'd3;

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter with a done flag; done is high whenever the count
// has reached zero, so loading N-1 yields exactly N cycles before done.
module seq_timer #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [WIDTH-1:0] value_i,
   output logic             done_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = value_i;
      end else if (count_q != '0) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done_o = (count_q == '0);

endmodule

// File: rtl/conv_block_sequencer.sv
// Host-facing controller that walks Fsmv through LOAD, gap, SoP and RUN
// phases for each block of a multi-block convolution job.
module conv_block_sequencer
   import conv_seq_pkg::*;
#(
   parameter int                     NB_IMAGE   = 10,
   parameter int                     NB_BLOCK   = 8,
   parameter int                     SOP_GAP    = 6,
   parameter int                     SOP_WIDTH  = 4,
   parameter int                     NB_TIMEOUT = 16,
   parameter logic [NB_TIMEOUT-1:0]  TIMEOUT    = 16'd4000
) (
   input  logic                i_CLK,
   input  logic                i_reset,
   input  logic                i_cmd_valid,
   input  logic [1:0]          i_cmd_op,
   input  logic [NB_IMAGE-1:0] i_cmd_imgLength,
   input  logic [NB_BLOCK-1:0] i_cmd_nBlocks,
   input  logic                i_data_valid,
   input  logic                i_fsm_EoP,
   input  logic                i_fsm_changeBlock,
   output logic                o_cmd_ready,
   output logic                o_fsm_load,
   output logic                o_fsm_valid,
   output logic                o_fsm_SoP,
   output logic [NB_IMAGE-1:0] o_fsm_imgLength,
   output logic                o_busy,
   output logic                o_done,
   output logic [NB_BLOCK-1:0] o_blockCount,
   output logic [1:0]          o_errCode
);

   seqState_t             state_q, state_d;
   logic [NB_IMAGE-1:0]   imgLen_q, imgLen_d;
   logic [NB_BLOCK-1:0]   nBlocks_q, nBlocks_d;
   logic [NB_IMAGE-1:0]   colCnt_q, colCnt_d;
   logic [NB_BLOCK-1:0]   blockCount_q, blockCount_d;
   logic [1:0]            errCode_q, errCode_d;
   logic                  load_q, load_d;
   logic                  valid_q, valid_d;
   logic                  sop_q, sop_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic                  ready_q, ready_d;

   logic                  cmdAbort;
   logic                  timerLoad;
   logic [NB_TIMEOUT-1:0] timerValue;
   logic                  timerDone;
   logic [NB_BLOCK-1:0]   nextBlockCount;
   logic                  unusedChangeBlock;

   // Fsmv's block-change flag carries no information the sequencer needs.
   assign unusedChangeBlock = i_fsm_changeBlock;

   assign cmdAbort       = i_cmd_valid && (i_cmd_op == OP_ABORT);
   assign nextBlockCount = blockCount_q + NB_BLOCK'(1);

   seq_timer #(
      .WIDTH (NB_TIMEOUT)
   ) u_timer (
      .clk_i   (i_CLK),
      .rst_ni  (i_reset),
      .load_i  (timerLoad),
      .value_i (timerValue),
      .done_o  (timerDone)
   );

   always_ff @(posedge i_CLK) begin
      if (!i_reset) begin
         state_q      <= ST_IDLE;
         imgLen_q     <= '0;
         nBlocks_q    <= '0;
         colCnt_q     <= '0;
         blockCount_q <= '0;
         errCode_q    <= ERR_NONE;
         load_q       <= 1'b0;
         valid_q      <= 1'b0;
         sop_q        <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         imgLen_q     <= imgLen_d;
         nBlocks_q    <= nBlocks_d;
         colCnt_q     <= colCnt_d;
         blockCount_q <= blockCount_d;
         errCode_q    <= errCode_d;
         load_q       <= load_d;
         valid_q      <= valid_d;
         sop_q        <= sop_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
         ready_q      <= ready_d;
      end
   end

   // The shared timer is (re)loaded on each transition into GAP, SOP or RUN.
   always_comb begin
      state_d      = state_q;
      imgLen_d     = imgLen_q;
      nBlocks_d    = nBlocks_q;
      colCnt_d     = colCnt_q;
      blockCount_d = blockCount_q;
      errCode_d    = errCode_q;
      timerLoad    = 1'b0;
      timerValue   = '0;
      if (cmdAbort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_cmd_valid) begin
                  if ((i_cmd_op == OP_START) && (i_cmd_nBlocks != '0)) begin
                     state_d      = ST_LOAD;
                     imgLen_d     = i_cmd_imgLength;
                     nBlocks_d    = i_cmd_nBlocks;
                     colCnt_d     = '0;
                     blockCount_d = '0;
                     errCode_d    = ERR_NONE;
                  end else if ((i_cmd_op == OP_START) || (i_cmd_op == OP_RSVD)) begin
                     errCode_d = ERR_BAD_CMD;
                  end
               end
            end
            ST_LOAD: begin
               if (i_data_valid) begin
                  if (colCnt_q == imgLen_q) begin
                     state_d    = ST_GAP;
                     colCnt_d   = '0;
                     timerLoad  = 1'b1;
                     timerValue = NB_TIMEOUT'(SOP_GAP - 1);
                  end else begin
                     colCnt_d = colCnt_q + NB_IMAGE'(1);
                  end
               end
            end
            ST_GAP: begin
               if (timerDone) begin
                  state_d    = ST_SOP;
                  timerLoad  = 1'b1;
                  timerValue = NB_TIMEOUT'(SOP_WIDTH - 1);
               end
            end
            ST_SOP: begin
               if (timerDone) begin
                  state_d    = ST_RUN;
                  timerLoad  = 1'b1;
                  timerValue = TIMEOUT - NB_TIMEOUT'(1);
               end
            end
            ST_RUN: begin
               // EoP is checked first so it wins over a simultaneous expiry.
               if (i_fsm_EoP) begin
                  blockCount_d = nextBlockCount;
                  if (nextBlockCount == nBlocks_q) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d  = ST_LOAD;
                     colCnt_d = '0;
                  end
               end else if (timerDone) begin
                  state_d   = ST_IDLE;
                  errCode_d = ERR_TIMEOUT;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
         if (i_fsm_EoP && (state_q != ST_RUN)) begin
            errCode_d = ERR_SPURIOUS_EOP;
         end
      end
   end

   // Outputs are decoded from the next state so they leave the flops aligned with it.
   always_comb begin
      load_d  = (state_d == ST_LOAD);
      valid_d = (state_q == ST_LOAD) && i_data_valid && !cmdAbort;
      sop_d   = (state_d == ST_SOP);
      done_d  = (state_d == ST_DONE);
      busy_d  = (state_d != ST_IDLE);
      ready_d = (state_d == ST_IDLE);
   end

   assign o_cmd_ready     = ready_q;
   assign o_fsm_load      = load_q;
   assign o_fsm_valid     = valid_q;
   assign o_fsm_SoP       = sop_q;
   assign o_fsm_imgLength = imgLen_q;
   assign o_busy          = busy_q;
   assign o_done          = done_q;
   assign o_blockCount    = blockCount_q;
   assign o_errCode       = errCode_q;

endmodule

// File: tb/tb_conv_block_sequencer.sv
// Scoreboard bench for conv_block_sequencer: per-block and per-job
// expectations are queued by the driver and consumed by a negedge monitor.
module tb_conv_block_sequencer;

   localparam int NB_IMAGE  = 10;
   localparam int NB_BLOCK  = 8;
   localparam int EXP_GAP   = 6;
   localparam int EXP_SOPW  = 4;
   localparam int EXP_TMO   = 4000;

   typedef struct {
      int cols;
      int prior;
   } blockExp_t;

   typedef struct {
      int blocks;
      int err;
   } jobExp_t;

   logic                i_CLK = 1'b0;
   logic                i_reset = 1'b0;
   logic                i_cmd_valid = 1'b0;
   logic [1:0]          i_cmd_op = 2'd0;
   logic [NB_IMAGE-1:0] i_cmd_imgLength = '0;
   logic [NB_BLOCK-1:0] i_cmd_nBlocks = '0;
   logic                i_data_valid = 1'b0;
   logic                i_fsm_EoP = 1'b0;
   logic                i_fsm_changeBlock = 1'b0;
   logic                o_cmd_ready;
   logic                o_fsm_load;
   logic                o_fsm_valid;
   logic                o_fsm_SoP;
   logic [NB_IMAGE-1:0] o_fsm_imgLength;
   logic                o_busy;
   logic                o_done;
   logic [NB_BLOCK-1:0] o_blockCount;
   logic [1:0]          o_errCode;

   int checks = 0;
   int errors = 0;
   int doneCnt = 0;
   blockExp_t colQ[$];
   jobExp_t   jobQ[$];

   conv_block_sequencer dut (
      .i_CLK             (i_CLK),
      .i_reset           (i_reset),
      .i_cmd_valid       (i_cmd_valid),
      .i_cmd_op          (i_cmd_op),
      .i_cmd_imgLength   (i_cmd_imgLength),
      .i_cmd_nBlocks     (i_cmd_nBlocks),
      .i_data_valid      (i_data_valid),
      .i_fsm_EoP         (i_fsm_EoP),
      .i_fsm_changeBlock (i_fsm_changeBlock),
      .o_cmd_ready       (o_cmd_ready),
      .o_fsm_load        (o_fsm_load),
      .o_fsm_valid       (o_fsm_valid),
      .o_fsm_SoP         (o_fsm_SoP),
      .o_fsm_imgLength   (o_fsm_imgLength),
      .o_busy            (o_busy),
      .o_done            (o_done),
      .o_blockCount      (o_blockCount),
      .o_errCode         (o_errCode)
   );

   always #5 i_CLK = ~i_CLK;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge i_CLK);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] op, input int len, input int nb);
      i_cmd_valid     = 1'b1;
      i_cmd_op        = op;
      i_cmd_imgLength = NB_IMAGE'(len);
      i_cmd_nBlocks   = NB_BLOCK'(nb);
      tick();
      i_cmd_valid = 1'b0;
      i_cmd_op    = 2'd0;
   endtask

   task automatic sendStrobes(input int n);
      i_data_valid = 1'b1;
      repeat (n) tick();
      i_data_valid = 1'b0;
   endtask

   task automatic pulseEoP();
      i_fsm_EoP = 1'b1;
      tick();
      i_fsm_EoP = 1'b0;
   endtask

   task automatic waitSopFall();
      int n;
      n = 0;
      while (!o_fsm_SoP && n < 200) begin tick(); n++; end
      checkOutput("sopRiseTimeout", 32'(o_fsm_SoP), 1);
      n = 0;
      while (o_fsm_SoP && n < 20) begin tick(); n++; end
      checkOutput("sopFallTimeout", 32'(o_fsm_SoP), 0);
   endtask

   task automatic waitIdle(input int budget, output int n);
      n = 0;
      while (o_busy && n < budget) begin tick(); n++; end
      checkOutput("idleTimeout", 32'(o_busy), 0);
   endtask

   // One complete block after the sequencer is in LOAD: columns, SoP, then EoP.
   task automatic runBlock(input int len, input int prior);
      colQ.push_back('{cols: len + 1, prior: prior});
      sendStrobes(len + 1);
      checkOutput("loadDropAfterLast", 32'(o_fsm_load), 0);
      checkOutput("lastStrobeForward", 32'(o_fsm_valid), 1);
      waitSopFall();
      repeat (26) tick();
      pulseEoP();
   endtask

   task automatic runJob(input int len, input int nb);
      int n;
      jobQ.push_back('{blocks: nb, err: 0});
      applyStimulus(2'd1, len, nb);
      checkOutput("startLoad", 32'(o_fsm_load), 1);
      checkOutput("startErr", 32'(o_errCode), 0);
      checkOutput("startLen", 32'(o_fsm_imgLength), len);
      for (int b = 0; b < nb; b++) runBlock(len, b);
      waitIdle(20, n);
      checkOutput("jobReady", 32'(o_cmd_ready), 1);
   endtask

   bit loadPrev = 1'b0;
   bit sopPrev = 1'b0;
   bit gapArmed = 1'b0;
   int gapCnt = 0;
   int sopW = 0;
   int validCnt = 0;

   always @(negedge i_CLK) begin
      blockExp_t be;
      jobExp_t je;
      if (o_fsm_load && !loadPrev) validCnt = 0;
      if (o_fsm_valid) validCnt++;
      if (!o_fsm_load && loadPrev) begin
         gapCnt   = 0;
         gapArmed = 1'b1;
      end
      if (gapArmed && !o_fsm_load && !o_fsm_SoP) gapCnt++;
      if (o_fsm_SoP && !sopPrev) begin
         checkOutput("sopGap", gapCnt, EXP_GAP);
         gapArmed = 1'b0;
         sopW     = 0;
         if (colQ.size() == 0) begin
            checkOutput("colUnderflow", 0, 1);
         end else begin
            be = colQ.pop_front();
            checkOutput("colCount", validCnt, be.cols);
            checkOutput("blockStep", 32'(o_blockCount), be.prior);
         end
      end
      if (o_fsm_SoP) sopW++;
      if (!o_fsm_SoP && sopPrev) checkOutput("sopWidth", sopW, EXP_SOPW);
      if (o_done) begin
         doneCnt++;
         if (jobQ.size() == 0) begin
            checkOutput("jobUnderflow", 0, 1);
         end else begin
            je = jobQ.pop_front();
            checkOutput("doneBlocks", 32'(o_blockCount), je.blocks);
            checkOutput("doneErr", 32'(o_errCode), je.err);
         end
      end
      loadPrev = o_fsm_load;
      sopPrev  = o_fsm_SoP;
   end

   initial begin
      #2ms;
      $display("[TB] FAIL globalTimeout observed=1 expected=0");
      $fatal(1, "[TB] simulation time limit");
   end

   initial begin
      int n;
      repeat (3) tick();
      checkOutput("rstReady", 32'(o_cmd_ready), 1);
      checkOutput("rstBusy", 32'(o_busy), 0);
      checkOutput("rstLoad", 32'(o_fsm_load), 0);
      checkOutput("rstErr", 32'(o_errCode), 0);
      checkOutput("rstBlocks", 32'(o_blockCount), 0);
      checkOutput("rstLen", 32'(o_fsm_imgLength), 0);
      i_reset = 1'b1;
      tick();

      $display("[TB] single block, length 15");
      runJob(15, 1);
      checkOutput("job1Blocks", 32'(o_blockCount), 1);
      checkOutput("job1Err", 32'(o_errCode), 0);

      $display("[TB] three blocks, length 3");
      runJob(3, 3);
      checkOutput("job2Blocks", 32'(o_blockCount), 3);
      checkOutput("job2Dones", doneCnt, 2);

      $display("[TB] zero block count");
      applyStimulus(2'd1, 7, 0);
      checkOutput("zeroErr", 32'(o_errCode), 1);
      checkOutput("zeroBusy", 32'(o_busy), 0);
      tick();
      checkOutput("zeroBusyLater", 32'(o_busy), 0);

      $display("[TB] run watchdog, length 0");
      applyStimulus(2'd1, 0, 1);
      checkOutput("tmoStartErr", 32'(o_errCode), 0);
      colQ.push_back('{cols: 1, prior: 0});
      sendStrobes(1);
      checkOutput("tmoLoadDrop", 32'(o_fsm_load), 0);
      waitSopFall();
      waitIdle(EXP_TMO + 100, n);
      checkOutput("tmoCycles", n, EXP_TMO);
      checkOutput("tmoErr", 32'(o_errCode), 2);
      checkOutput("tmoReady", 32'(o_cmd_ready), 1);

      $display("[TB] abort in second block, then reset");
      applyStimulus(2'd1, 15, 2);
      runBlock(15, 0);
      sendStrobes(5);
      checkOutput("preAbortLoad", 32'(o_fsm_load), 1);
      applyStimulus(2'd2, 0, 0);
      checkOutput("abortLoad", 32'(o_fsm_load), 0);
      checkOutput("abortValid", 32'(o_fsm_valid), 0);
      checkOutput("abortBusy", 32'(o_busy), 0);
      checkOutput("abortReady", 32'(o_cmd_ready), 1);
      checkOutput("abortBlocks", 32'(o_blockCount), 1);
      checkOutput("abortErr", 32'(o_errCode), 0);
      checkOutput("abortLen", 32'(o_fsm_imgLength), 15);
      i_reset = 1'b0;
      tick();
      i_reset = 1'b1;
      checkOutput("rst2Blocks", 32'(o_blockCount), 0);
      checkOutput("rst2Len", 32'(o_fsm_imgLength), 0);
      checkOutput("rst2Ready", 32'(o_cmd_ready), 1);
      checkOutput("rst2Busy", 32'(o_busy), 0);

      $display("[TB] spurious EoP while idle");
      pulseEoP();
      checkOutput("spurErr", 32'(o_errCode), 3);
      checkOutput("spurBusy", 32'(o_busy), 0);
      runJob(3, 1);
      checkOutput("finalErr", 32'(o_errCode), 0);

      tick();
      checkOutput("doneTotal", doneCnt, 3);
      checkOutput("colQEmpty", colQ.size(), 0);
      checkOutput("jobQEmpty", jobQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
